gf2_col_mult: RTL and testbench

//  GF(2) matrix-vector multiplier directly downstream of the row-selection stage.

---
 rtl/gf2_col_mult_if.sv | 28 ++
 rtl/gf2_col_mult.sv | 85 ++++++++
 tb/tb_gf2_col_mult.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_col_mult_if.sv
// Bundle of the product-request, column-stream and result handshake signals of gf2_col_mult.
// master: the environment (row selector, producer, consumer); slave: the multiplier.
interface gf2_col_mult_if #(
  parameter int unsigned N = 128,
  parameter int unsigned K = 128
) ();
  logic         start;
  logic         matrix_ready;
  logic [K-1:0] secret;
  logic [N-1:0] offset;
  logic         clear;
  logic         shift_en;
  logic [N-1:0] col_in;
  logic [N-1:0] result;
  logic         result_valid;
  logic         result_ack;
  logic         busy;

  modport master (
    output start, matrix_ready, secret, offset, clear, col_in, result_ack,
    input  shift_en, result, result_valid, busy
  );

  modport slave (
    input  start, matrix_ready, secret, offset, clear, col_in, result_ack,
    output shift_en, result, result_valid, busy
  );
endinterface

// File: rtl/gf2_col_mult.sv
// GF(2) matrix-vector multiplier: streams K columns from the row selector and accumulates
// r = offset ^ (A * s), then holds r under a valid/ack handshake.
module gf2_col_mult #(
  parameter int unsigned N = 128,
  parameter int unsigned K = 128
) (
  input logic          clk,
  input logic          resetn,
  gf2_col_mult_if.slave bus
);
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [K-1:0]    s_q;
  logic [N-1:0]    acc_q;
  logic [CntW-1:0] cnt_q;
  logic            shift_en_q;
  logic            valid_q;
  logic            busy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      s_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      shift_en_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else if (bus.clear) begin
      state_q    <= StIdle;
      s_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      shift_en_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && bus.matrix_ready) begin
            s_q        <= bus.secret;
            acc_q      <= bus.offset;
            cnt_q      <= '0;
            state_q    <= StRun;
            shift_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          // col_in is column cnt_q; the selector advances on this same edge.
          acc_q <= acc_q ^ (s_q[0] ? bus.col_in : '0);
          s_q   <= s_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q    <= StDone;
            shift_en_q <= 1'b0;
            valid_q    <= 1'b1;
          end
        end
        StDone: begin
          if (bus.result_ack) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          shift_en_q <= 1'b0;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shift_en     = shift_en_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.result       = acc_q;
endmodule

// File: tb/tb_gf2_col_mult.sv
// Directed bench for gf2_col_mult: models the row selector's column stream and checks
// products, shift counts, handshake, clear and asynchronous reset.
module tb_gf2_col_mult;
  localparam int unsigned N = 128;
  localparam int unsigned K = 128;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gf2_col_mult_if #(.N(N), .K(K)) bus ();

  gf2_col_mult #(.N(N), .K(K)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int col_idx = 0;

  // 0: one-hot columns, 1: all-ones columns, other: scrambled columns
  function automatic logic [N-1:0] col_of(input int m, input int j);
    logic [31:0] w;
    w = 32'(j) * 32'h9E37_79B9 + 32'h1234_5678;
    case (m)
      0:       col_of = (j < int'(K)) ? (N'(1) << j) : '0;
      1:       col_of = '1;
      default: col_of = {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd7};
    endcase
  endfunction

  // Selector model: advances on every edge where shift_en is sampled high.
  always @(posedge clk) begin
    if (bus.shift_en) col_idx <= col_idx + 1;
    else if (!bus.busy) col_idx <= 0;
  end

  always_comb bus.col_in = col_of(mode, col_idx);

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch one product and watch it until result_valid (bounded); optionally pulse start
  // with different operands after pulse_at shift cycles.
  task automatic run_product(input logic [K-1:0] s, input logic [N-1:0] off, input int pulse_at,
                             output int shifts, output logic got_valid);
    @(negedge clk);
    bus.secret = s;
    bus.offset = off;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    shifts     = 0;
    got_valid  = 1'b0;
    for (int c = 0; c < 400 && !got_valid; c++) begin
      if (bus.shift_en) shifts++;
      if (bus.result_valid) begin
        got_valid = 1'b1;
      end else begin
        bus.start = (shifts == pulse_at);
        if (shifts == pulse_at) begin
          bus.secret = ~s;
          bus.offset = ~off;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic ack_result();
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
  endtask

  int   shifts;
  logic got_valid;
  logic [N-1:0] held;

  initial begin
    bus.start        = 1'b0;
    bus.matrix_ready = 1'b1;
    bus.secret       = '0;
    bus.offset       = '0;
    bus.clear        = 1'b0;
    bus.result_ack   = 1'b0;

    #2;
    chk1("rst_shift_en", bus.shift_en, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_valid", bus.result_valid, 1'b0);
    chk("rst_result", bus.result, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // One-hot columns return s unchanged
    mode = 0;
    run_product(128'h0123456789ABCDEF_FEDCBA9876543210, '0, -1, shifts, got_valid);
    chk1("t1_valid", got_valid, 1'b1);
    chkn("t1_shifts", shifts, 128);
    chk("t1_result", bus.result, 128'h0123456789ABCDEF_FEDCBA9876543210);
    chk1("t1_busy", bus.busy, 1'b1);
    ack_result();
    chk1("t1_idle", bus.busy, 1'b0);

    // s = 0 leaves the offset
    mode = 2;
    run_product('0, {16{8'hA5}}, -1, shifts, got_valid);
    chk1("t2_valid", got_valid, 1'b1);
    chkn("t2_shifts", shifts, 128);
    chk("t2_result", bus.result, {16{8'hA5}});
    ack_result();

    // All-ones columns: parity of popcount(s)
    mode = 1;
    run_product(128'h8000_0000_0000_0001_0000_0000_0000_0001, '0, -1, shifts, got_valid);
    chk1("t3a_valid", got_valid, 1'b1);
    chk("t3a_result", bus.result, '1);
    ack_result();
    run_product(128'h8000_0000_0000_0001_0000_0000_0000_0003, '0, -1, shifts, got_valid);
    chk1("t3b_valid", got_valid, 1'b1);
    chk("t3b_result", bus.result, '0);
    ack_result();

    // start without matrix_ready is dropped and not remembered
    bus.matrix_ready = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk1("t4a_shift_en", bus.shift_en, 1'b0);
    chk1("t4a_busy", bus.busy, 1'b0);
    bus.matrix_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("t4a_no_memory", bus.busy, 1'b0);

    // start mid-run is ignored; operands not resampled
    mode = 0;
    run_product(128'h0123456789ABCDEF_FEDCBA9876543210, '0, 40, shifts, got_valid);
    chk1("t4b_valid", got_valid, 1'b1);
    chkn("t4b_shifts", shifts, 128);
    chk("t4b_result", bus.result, 128'h0123456789ABCDEF_FEDCBA9876543210);

    // Result held while ack is low
    held = bus.result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("t5_valid_hold", bus.result_valid, 1'b1);
      chk("t5_result_hold", bus.result, held);
    end
    // ack with start in DONE: back to IDLE, no new product
    bus.result_ack = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    bus.start = 1'b0;
    chk1("t5_ack_valid", bus.result_valid, 1'b0);
    chk1("t5_ack_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk1("t5_no_start", bus.shift_en, 1'b0);
    chk1("t5_no_start_busy", bus.busy, 1'b0);

    // Async reset mid-run
    bus.secret = 128'hFFFF;
    bus.offset = 128'h1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    shifts = 0;
    for (int c = 0; c < 200 && shifts < 60; c++) begin
      if (bus.shift_en) shifts++;
      if (shifts < 60) @(negedge clk);
    end
    chkn("t6a_reached", shifts, 60);
    #1 resetn = 1'b0;
    #1;
    chk1("t6a_shift_en", bus.shift_en, 1'b0);
    chk1("t6a_busy", bus.busy, 1'b0);
    chk1("t6a_valid", bus.result_valid, 1'b0);
    chk("t6a_result", bus.result, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("t6a_stays_idle", bus.busy, 1'b0);

    // clear mid-run, then a clean product
    bus.secret = 128'hFFFF;
    bus.offset = 128'h1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    shifts = 0;
    for (int c = 0; c < 200 && shifts < 60; c++) begin
      if (bus.shift_en) shifts++;
      if (shifts < 60) @(negedge clk);
    end
    chkn("t6b_reached", shifts, 60);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk1("t6b_shift_en", bus.shift_en, 1'b0);
    chk1("t6b_busy", bus.busy, 1'b0);
    chk("t6b_result", bus.result, '0);
    @(negedge clk);
    run_product({8{16'h0F0F}}, {8{16'hFF00}}, -1, shifts, got_valid);
    chk1("t6b_valid", got_valid, 1'b1);
    chkn("t6b_shifts", shifts, 128);
    chk("t6b_clean", bus.result, {8{16'hF00F}});
    ack_result();

    // clear beats start in IDLE
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk1("t7_clear_wins", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
